// File: rtl/display_scan_mux_if.sv
// Signal bundle between the display datapath and the scanner.
// No valid/ready handshake: the scanner samples en, ch_mask and data_in on every rising edge, and its outputs are registered.
interface display_scan_mux_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 4
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     en;
    logic [N_CH-1:0]          ch_mask;
    logic [N_CH*DATA_W-1:0]   data_in;
    logic [N_CH-1:0]          sel;
    logic [DATA_W-1:0]        data_out;
    logic [IW-1:0]            idx;
    logic                     frame_tick;
    logic [1:0]               state;

    modport master (
        output en, ch_mask, data_in,
        input  sel, data_out, idx, frame_tick, state
    );

    modport slave (
        input  en, ch_mask, data_in,
        output sel, data_out, idx, frame_tick, state
    );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed display scanner: one-hot channel enable with dwell, guard blanking,
// per-channel masking and a frame-complete pulse on scan wrap-around.
module display_scan_mux #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 4,
    parameter int DWELL  = 1000,
    parameter int GUARD  = 2
) (
    input  logic               clk,
    input  logic               reset,
    display_scan_mux_if.slave  bus
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;
    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam bit HAS_GUARD = (GUARD > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [IW-1:0]       r_idx, w_idx_nxt;
    logic [DW-1:0]       r_dwell_cnt, w_dwell_nxt;
    logic [GW-1:0]       r_guard_cnt, w_guard_nxt;
    logic [N_CH-1:0]     r_sel, w_sel_nxt;
    logic [DATA_W-1:0]   r_data_out, w_data_nxt;
    logic                r_frame_tick, w_tick_nxt;
    logic [IW-1:0]       w_adv_idx;

    // Next set mask bit strictly after cur, wrapping; returns cur when it is the only one set.
    function automatic logic [IW-1:0] next_set(input logic [N_CH-1:0] m, input logic [IW-1:0] cur);
        logic [IW-1:0] res;
        logic          found;
        int            j;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            j = int'(cur) + i;
            if (j >= N_CH) j = j - N_CH;
            if (!found && m[j]) begin
                res   = IW'(j);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] lowest_set(input logic [N_CH-1:0] m);
        logic [IW-1:0] res;
        res = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) res = IW'(i);
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_dwell_cnt  <= '0;
            r_guard_cnt  <= '0;
            r_sel        <= '0;
            r_data_out   <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_dwell_cnt  <= w_dwell_nxt;
            r_guard_cnt  <= w_guard_nxt;
            r_sel        <= w_sel_nxt;
            r_data_out   <= w_data_nxt;
            r_frame_tick <= w_tick_nxt;
        end
    end

    assign w_adv_idx = next_set(bus.ch_mask, r_idx);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_dwell_nxt = '0;
        w_guard_nxt = '0;
        w_tick_nxt  = 1'b0;
        if (!bus.en || (bus.ch_mask == '0)) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_idx_nxt   = lowest_set(bus.ch_mask);
                    w_state_nxt = HAS_GUARD ? S_BLANK : S_ON;
                end
                S_BLANK: begin
                    if (r_guard_cnt == GUARD_LAST) begin
                        w_state_nxt = S_ON;
                        // Target may have been masked while blanking: pick the next live channel.
                        if (!bus.ch_mask[r_idx]) w_idx_nxt = w_adv_idx;
                    end else begin
                        w_guard_nxt = r_guard_cnt + 1'b1;
                    end
                end
                S_ON: begin
                    if ((r_dwell_cnt == DWELL_LAST) || !bus.ch_mask[r_idx]) begin
                        w_idx_nxt   = w_adv_idx;
                        w_tick_nxt  = (w_adv_idx <= r_idx);
                        w_state_nxt = HAS_GUARD ? S_BLANK : S_ON;
                    end else begin
                        w_dwell_nxt = r_dwell_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_sel_nxt  = '0;
        w_data_nxt = '0;
        if (w_state_nxt == S_ON) begin
            w_sel_nxt[w_idx_nxt] = 1'b1;
            w_data_nxt           = bus.data_in[int'(w_idx_nxt) * DATA_W +: DATA_W];
        end
    end

    assign bus.sel        = r_sel;
    assign bus.data_out   = r_data_out;
    assign bus.idx        = r_idx;
    assign bus.frame_tick = r_frame_tick;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: a GUARD=1 build for the main scan scenarios
// and a GUARD=0 build for the single-channel continuous case.
module tb_display_scan_mux;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    display_scan_mux_if #(.N_CH(4), .DATA_W(4)) if_a ();
    display_scan_mux_if #(.N_CH(4), .DATA_W(4)) if_b ();

    display_scan_mux #(.N_CH(4), .DATA_W(4), .DWELL(3), .GUARD(1)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave)
    );
    display_scan_mux #(.N_CH(4), .DATA_W(4), .DWELL(3), .GUARD(0)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_sel [18] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                                    4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};
        logic [3:0] exp_dat [18] = '{4'h0, 4'h3, 4'h3, 4'h3, 4'h0, 4'hA, 4'hA, 4'hA, 4'h0,
                                    4'h5, 4'h5, 4'h5, 4'h0, 4'hD, 4'hD, 4'hD, 4'h0, 4'h3};
        logic [1:0] exp_idx [18] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                                    2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
        step();
        checks++;
        if ({if_a.sel, if_a.data_out, if_a.idx, if_a.frame_tick, if_a.state} !== 13'd0) begin
            failures++;
            $display("FAIL reset_values got sel=%b data=%h idx=%0d tick=%b state=%0d exp all 0",
                     if_a.sel, if_a.data_out, if_a.idx, if_a.frame_tick, if_a.state);
        end
        if_a.en      = 1'b1;
        if_a.ch_mask = 4'b1111;
        reset        = 1'b0;
        for (int c = 0; c < 18; c++) begin
            step();
            checks++;
            if (if_a.sel !== exp_sel[c]) begin
                failures++;
                $display("FAIL scan_sel cycle %0d got %b exp %b", c + 1, if_a.sel, exp_sel[c]);
            end
            checks++;
            if (if_a.data_out !== exp_dat[c]) begin
                failures++;
                $display("FAIL scan_data cycle %0d got %h exp %h", c + 1, if_a.data_out, exp_dat[c]);
            end
            checks++;
            if (if_a.idx !== exp_idx[c]) begin
                failures++;
                $display("FAIL scan_idx cycle %0d got %0d exp %0d", c + 1, if_a.idx, exp_idx[c]);
            end
            checks++;
            if (if_a.frame_tick !== (c == 16)) begin
                failures++;
                $display("FAIL scan_tick cycle %0d got %b exp %b", c + 1, if_a.frame_tick, (c == 16));
            end
        end
    endtask

    task automatic test_skip();
        logic [3:0] exp_sel [17] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0,
                                    4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};
        logic [3:0] exp_dat [17] = '{4'h0, 4'hA, 4'hA, 4'hA, 4'h0, 4'hD, 4'hD, 4'hD, 4'h0,
                                    4'hA, 4'hA, 4'hA, 4'h0, 4'hD, 4'hD, 4'hD, 4'h0};
        if_a.en = 1'b0;
        step();
        checks++;
        if (if_a.state !== 2'd0 || if_a.sel !== 4'h0) begin
            failures++;
            $display("FAIL skip_idle got state=%0d sel=%b exp state=0 sel=0000", if_a.state, if_a.sel);
        end
        if_a.ch_mask = 4'b1010;
        if_a.en      = 1'b1;
        for (int c = 0; c < 17; c++) begin
            step();
            checks++;
            if (if_a.sel !== exp_sel[c]) begin
                failures++;
                $display("FAIL skip_sel cycle %0d got %b exp %b", c + 1, if_a.sel, exp_sel[c]);
            end
            checks++;
            if (if_a.data_out !== exp_dat[c]) begin
                failures++;
                $display("FAIL skip_data cycle %0d got %h exp %h", c + 1, if_a.data_out, exp_dat[c]);
            end
            checks++;
            if (if_a.frame_tick !== (c == 8 || c == 16)) begin
                failures++;
                $display("FAIL skip_tick cycle %0d got %b exp %b", c + 1, if_a.frame_tick, (c == 8 || c == 16));
            end
        end
    endtask

    task automatic test_mask_change();
        if_a.en = 1'b0;
        step();
        if_a.ch_mask = 4'b1111;
        if_a.en      = 1'b1;
        for (int c = 0; c < 7; c++) step();
        checks++;
        if (if_a.sel !== 4'b0010) begin
            failures++;
            $display("FAIL mask_ch1_on got %b exp 0010", if_a.sel);
        end
        if_a.ch_mask = 4'b1101;
        step();
        checks++;
        if (if_a.sel !== 4'b0000 || if_a.idx !== 2'd2 || if_a.frame_tick !== 1'b0) begin
            failures++;
            $display("FAIL mask_clear_blank got sel=%b idx=%0d tick=%b exp 0000 2 0",
                     if_a.sel, if_a.idx, if_a.frame_tick);
        end
        step();
        checks++;
        if (if_a.sel !== 4'b0100 || if_a.data_out !== 4'h5) begin
            failures++;
            $display("FAIL mask_clear_next got sel=%b data=%h exp 0100 5", if_a.sel, if_a.data_out);
        end
        if_a.ch_mask = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (if_a.state !== 2'd0 || if_a.sel !== 4'h0 || if_a.data_out !== 4'h0 || if_a.frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL mask_zero_idle cycle %0d got state=%0d sel=%b data=%h tick=%b exp 0 0000 0 0",
                         c, if_a.state, if_a.sel, if_a.data_out, if_a.frame_tick);
            end
        end
    endtask

    task automatic test_en_drop();
        if_a.ch_mask = 4'b1111;
        for (int c = 0; c < 10; c++) step();
        checks++;
        if (if_a.sel !== 4'b0100) begin
            failures++;
            $display("FAIL en_ch2_on got %b exp 0100", if_a.sel);
        end
        if_a.en = 1'b0;
        step();
        checks++;
        if (if_a.sel !== 4'h0 || if_a.data_out !== 4'h0 || if_a.state !== 2'd0 || if_a.idx !== 2'd2) begin
            failures++;
            $display("FAIL en_drop got sel=%b data=%h state=%0d idx=%0d exp 0000 0 0 2",
                     if_a.sel, if_a.data_out, if_a.state, if_a.idx);
        end
        if_a.en = 1'b1;
        step();
        checks++;
        if (if_a.sel !== 4'h0 || if_a.idx !== 2'd0 || if_a.state !== 2'd1) begin
            failures++;
            $display("FAIL en_restart_blank got sel=%b idx=%0d state=%0d exp 0000 0 1",
                     if_a.sel, if_a.idx, if_a.state);
        end
        step();
        checks++;
        if (if_a.sel !== 4'b0001 || if_a.data_out !== 4'h3) begin
            failures++;
            $display("FAIL en_restart_on got sel=%b data=%h exp 0001 3", if_a.sel, if_a.data_out);
        end
    endtask

    task automatic test_async_reset();
        step();
        checks++;
        if (if_a.sel !== 4'b0001) begin
            failures++;
            $display("FAIL areset_pre_on got %b exp 0001", if_a.sel);
        end
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (if_a.sel !== 4'h0 || if_a.data_out !== 4'h0) begin
            failures++;
            $display("FAIL areset_immediate got sel=%b data=%h exp 0000 0", if_a.sel, if_a.data_out);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({if_a.sel, if_a.data_out, if_a.idx, if_a.frame_tick, if_a.state} !== 13'd0) begin
                failures++;
                $display("FAIL areset_hold cycle %0d got sel=%b data=%h idx=%0d tick=%b state=%0d exp all 0",
                         c, if_a.sel, if_a.data_out, if_a.idx, if_a.frame_tick, if_a.state);
            end
        end
        if_a.en = 1'b0;
        reset   = 1'b0;
        step();
    endtask

    task automatic test_single_guard0();
        if_b.ch_mask = 4'b0100;
        if_b.en      = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            checks++;
            if (if_b.sel !== 4'b0100 || if_b.data_out !== 4'hB) begin
                failures++;
                $display("FAIL g0_sel cycle %0d got sel=%b data=%h exp 0100 b", c + 1, if_b.sel, if_b.data_out);
            end
            checks++;
            if (if_b.frame_tick !== (c == 3 || c == 6 || c == 9)) begin
                failures++;
                $display("FAIL g0_tick cycle %0d got %b exp %b", c + 1, if_b.frame_tick, (c == 3 || c == 6 || c == 9));
            end
        end
        if_b.en = 1'b0;
        step();
        checks++;
        if (if_b.sel !== 4'h0 || if_b.state !== 2'd0) begin
            failures++;
            $display("FAIL g0_disable got sel=%b state=%0d exp 0000 0", if_b.sel, if_b.state);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        if_a.en      = 1'b0;
        if_a.ch_mask = 4'b0000;
        if_a.data_in = 16'hD5A3;
        if_b.en      = 1'b0;
        if_b.ch_mask = 4'b0000;
        if_b.data_in = 16'h7B2E;
        test_reset();
        test_skip();
        test_mask_change();
        test_en_drop();
        test_async_reset();
        test_single_guard0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
